mr_regfile_sb: RTL and testbench
================================

// Module: mr_regfile_sb
// PURPOSE
//  Parametrised integer register file with write-pending scoreboard, for the decode stage.
//  Generalises the single-writeback decode regfile: configurable reg count/width, WB_PORTS writebacks, WB->read bypass.
//  Adds claim backpressure on counter saturation in place of an assertion, plus a pipeline flush and sticky error flags.
//  Decode reads rs1/rs2 and busy status, claims rd on issue; WB stage(s) retire writes.
// PARAMETERS
//  XLEN       32  register width in bits
//  NREGS      32  architectural registers incl. x0 (power of 2, >=2); RSEL=$clog2(NREGS) localparam
//  PEND_BITS  2   width of per-register pending-write counter (max in flight = 2**PEND_BITS-1)
//  WB_PORTS   1   number of independent writeback ports (1..4)
//  BYPASS     1   1: same-cycle WB data forwarded to read ports; 0: reads see registered file only
// PORTS
//  clk             in   1               clock, all state on posedge
//  rst             in   1               asynchronous active-high reset
//  rd_sel_a        in   RSEL            read port A register select
//  rd_data_a       out  XLEN            read port A data (combinational)
//  rd_busy_a       out  1               port A register has outstanding writes (combinational)
//  rd_sel_b        in   RSEL            read port B register select
//  rd_data_b       out  XLEN            read port B data (combinational)
//  rd_busy_b       out  1               port B busy (combinational)
//  claim_valid     in   1               issue wants to reserve claim_reg as destination
//  claim_reg       in   RSEL            destination register to reserve
//  claim_ready     out  1               claim accepted this cycle (combinational)
//  wb_valid        in   WB_PORTS        per-port writeback strobe
//  wb_reg          in   WB_PORTS*RSEL   per-port writeback register, port i at [i*RSEL+:RSEL]
//  wb_val          in   WB_PORTS*XLEN   per-port writeback data, port i at [i*XLEN+:XLEN]
//  flush           in   1               clear all pending counters (pipeline squash)
//  pending_any     out  1               registered: any counter non-zero
//  err_underflow   out  1               sticky: WB to register whose counter was 0
//  err_wb_conflict out  1               sticky: two WB ports hit same non-zero reg in one cycle
// BEHAVIOUR
//  Reset (async, rst=1): all regs 0, all counters 0, pending_any=0, both err flags=0; held while rst high.
//  x0: always reads 0, never busy; claims/WBs to reg 0 accepted (claim_ready=1) but change no state.
//  Read: data = file[sel]; if BYPASS and a valid WB port targets sel (!=0) this cycle, data = that wb_val
//    (highest-index port wins on conflict). busy = sel!=0 && eff_cnt[sel]!=0, where
//    eff_cnt = cnt - (BYPASS ? wb_hits[sel] : 0), saturating at 0; flush does not affect busy same cycle.
//  claim_ready = !rst && !flush && (claim_reg==0 || cnt[claim_reg] - wb_hits[claim_reg] < 2**PEND_BITS-1).
//    Accept = claim_valid && claim_ready; takes effect at next edge. Issue must hold claim_valid until ready.
//  Counter update per reg r at posedge (flush=0):
//    cnt' = cnt + (accept && claim_reg==r) - wb_hits[r]; wb_hits[r] = number of valid WB ports with wb_reg==r.
//    Simultaneous claim and WB to r: net change, no glitch. Result below 0: clamp 0, set err_underflow.
//  WB data: file[wb_reg] <= wb_val for every valid port, r!=0; on same-reg conflict highest index wins
//    and err_wb_conflict is set. WB data written regardless of flush or counter state.
//  flush=1: all counters <- 0 at edge; claim not accepted; WB decrements ignored (no underflow flag).
//  pending_any: registered OR of next-state counters (reflects cnt' one cycle after the edge that set it).
//  Err flags clear only on rst.
//  Latency: claim visible as busy on cycle after accept; WB visible in rd_data same cycle (BYPASS=1)
//    or next cycle (BYPASS=0); busy drops same cycle as last WB (BYPASS=1) or next cycle (BYPASS=0).
//  rst asserted mid-operation: all counters and regs zeroed immediately; claims/WBs that cycle lost.
// TESTING
//  Reset, then read x0..x31 -> all data 0, busy 0, pending_any 0, claim_ready 1.
//  Claim x5, next cycle read A=x5 -> busy_a=1; WB x5=0xDEADBEEF -> same cycle rd_data_a=0xDEADBEEF, busy_a=0 (BYPASS=1).
//  PEND_BITS=2: claim x7 three times -> claim_ready=0 on 4th; same cycle WB x7 -> claim_ready=1, cnt stays 3.
//  WB x9 with cnt 0 -> file updated, err_underflow=1, sticky until rst; cnt stays 0.
//  WB_PORTS=2: both ports write x3 (0x11,0x22) -> x3=0x22, err_wb_conflict=1, cnt drops by 2.
//  Claims on x1,x2 then flush with claim x4 -> all counters 0, x4 not claimed, pending_any=0 next cycle.

Source files
------------

// File: rtl/mr_regfile_sb.sv
// Integer register file for the decode stage with a per-register write-pending
// scoreboard, multiple writeback ports, optional WB->read forwarding, pipeline
// flush and sticky error flags.
module mr_regfile_sb #(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int PEND_BITS = 2,
   parameter int WB_PORTS  = 1,
   parameter int BYPASS    = 1,
   localparam int RSEL     = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [RSEL-1:0]          rd_sel_a,
   output logic [XLEN-1:0]          rd_data_a,
   output logic                     rd_busy_a,
   input  logic [RSEL-1:0]          rd_sel_b,
   output logic [XLEN-1:0]          rd_data_b,
   output logic                     rd_busy_b,
   input  logic                     claim_valid,
   input  logic [RSEL-1:0]          claim_reg,
   output logic                     claim_ready,
   input  logic [WB_PORTS-1:0]      wb_valid,
   input  logic [WB_PORTS*RSEL-1:0] wb_reg,
   input  logic [WB_PORTS*XLEN-1:0] wb_val,
   input  logic                     flush,
   output logic                     pending_any,
   output logic                     err_underflow,
   output logic                     err_wb_conflict
);

   // Hit counter is wide enough for up to four writeback ports on one register.
   localparam int HW      = 3;
   localparam int CNT_MAX = (1 << PEND_BITS) - 1;

   logic [XLEN-1:0]      file_q [NREGS];
   logic [XLEN-1:0]      file_d [NREGS];
   logic [PEND_BITS-1:0] cnt_q  [NREGS];
   logic [PEND_BITS-1:0] cnt_d  [NREGS];
   logic [HW-1:0]        wb_hits [NREGS];
   logic                 pending_any_q, pending_any_d;
   logic                 err_underflow_q, err_underflow_d;
   logic                 err_wb_conflict_q, err_wb_conflict_d;

   // Forwarded read data: registered value, overridden by the highest-index
   // valid writeback that targets the same non-zero register.
   function automatic logic [XLEN-1:0] read_data(
      input logic [RSEL-1:0]          sel,
      input logic [XLEN-1:0]          base,
      input logic [WB_PORTS-1:0]      v,
      input logic [WB_PORTS*RSEL-1:0] regs,
      input logic [WB_PORTS*XLEN-1:0] vals
   );
      logic [XLEN-1:0] d;
      d = base;
      if (BYPASS != 0) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (v[p] && regs[p*RSEL +: RSEL] == sel) d = vals[p*XLEN +: XLEN];
         end
      end
      if (sel == '0) d = '0;
      return d;
   endfunction

   // Busy uses the effective count: with forwarding, writebacks landing this
   // cycle already retire their pending entries.
   function automatic logic read_busy(
      input logic [RSEL-1:0]      sel,
      input logic [PEND_BITS-1:0] cnt,
      input logic [HW-1:0]        hits
   );
      if (sel == '0) return 1'b0;
      if (BYPASS != 0) return int'(cnt) > int'(hits);
      return cnt != '0;
   endfunction

   // Count valid writeback ports per register this cycle.
   always_comb begin
      // NOTE: every variable gets a default at the top of a combinational block, so no path can infer a latch.
      for (int r = 0; r < NREGS; r++) wb_hits[r] = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p]) wb_hits[wb_reg[p*RSEL +: RSEL]] = wb_hits[wb_reg[p*RSEL +: RSEL]] + HW'(1);
      end
   end

   // Read ports A and B.
   always_comb begin
      rd_data_a = read_data(rd_sel_a, file_q[rd_sel_a], wb_valid, wb_reg, wb_val);
      rd_busy_a = read_busy(rd_sel_a, cnt_q[rd_sel_a], wb_hits[rd_sel_a]);
      rd_data_b = read_data(rd_sel_b, file_q[rd_sel_b], wb_valid, wb_reg, wb_val);
      rd_busy_b = read_busy(rd_sel_b, cnt_q[rd_sel_b], wb_hits[rd_sel_b]);
   end

   // Claim backpressure: refuse when the counter would saturate after this cycle's retirements.
   always_comb begin
      claim_ready = 1'b0;
      if (!rst && !flush) begin
         if (claim_reg == '0) claim_ready = 1'b1;
         else claim_ready = (int'(cnt_q[claim_reg]) - int'(wb_hits[claim_reg])) < CNT_MAX;
      end
   end

   // Next-state: counters, file contents, sticky errors and pending summary.
   always_comb begin
      int   nxt;
      logic accept;
      nxt               = 0;
      accept            = claim_valid && claim_ready;
      cnt_d             = cnt_q;
      file_d            = file_q;
      err_underflow_d   = err_underflow_q;
      err_wb_conflict_d = err_wb_conflict_q;
      pending_any_d     = 1'b0;

      // x0 is skipped so its counter and contents stay zero.
      for (int r = 1; r < NREGS; r++) begin
         nxt = int'(cnt_q[r]) + ((accept && claim_reg == RSEL'(r)) ? 1 : 0) - int'(wb_hits[r]);
         if (flush) begin
            cnt_d[r] = '0;
         end else if (nxt < 0) begin
            cnt_d[r]        = '0;
            err_underflow_d = 1'b1;
         end else begin
            cnt_d[r] = PEND_BITS'(nxt);
         end
         if (wb_hits[r] > HW'(1)) err_wb_conflict_d = 1'b1;
      end

      // Later ports overwrite earlier ones, so the highest index wins a conflict.
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && wb_reg[p*RSEL +: RSEL] != '0)
            file_d[wb_reg[p*RSEL +: RSEL]] = wb_val[p*XLEN +: XLEN];
      end

      for (int r = 0; r < NREGS; r++) begin
         if (cnt_d[r] != '0) pending_any_d = 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the file itself is reset because x-free reads right after reset are required behaviour.
         for (int r = 0; r < NREGS; r++) begin
            file_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         pending_any_q     <= 1'b0;
         err_underflow_q   <= 1'b0;
         err_wb_conflict_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         file_q            <= file_d;
         cnt_q             <= cnt_d;
         pending_any_q     <= pending_any_d;
         err_underflow_q   <= err_underflow_d;
         err_wb_conflict_q <= err_wb_conflict_d;
      end
   end

   assign pending_any     = pending_any_q;
   assign err_underflow   = err_underflow_q;
   assign err_wb_conflict = err_wb_conflict_q;

endmodule

// File: tb/tb_mr_regfile_sb.sv
// Self-checking bench for mr_regfile_sb (2 writeback ports, forwarding on):
// directed scenarios followed by random traffic against a behavioural model.
module tb_mr_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int RSEL = 5;
   localparam int WBP = 2;
   localparam int MAXP = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [RSEL-1:0]   rd_sel_a, rd_sel_b, claim_reg;
   logic [XLEN-1:0]   rd_data_a, rd_data_b;
   logic              rd_busy_a, rd_busy_b;
   logic              claim_valid, claim_ready, flush;
   logic [WBP-1:0]    wb_valid;
   logic [WBP*RSEL-1:0] wb_reg;
   logic [WBP*XLEN-1:0] wb_val;
   logic              pending_any, err_underflow, err_wb_conflict;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int              m_cnt  [NREGS];
   logic [XLEN-1:0] m_file [NREGS];
   bit              m_pend, m_uf, m_cf;

   mr_regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .PEND_BITS(2), .WB_PORTS(WBP), .BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
      .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
      .claim_valid(claim_valid), .claim_reg(claim_reg), .claim_ready(claim_ready),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val),
      .flush(flush), .pending_any(pending_any),
      .err_underflow(err_underflow), .err_wb_conflict(err_wb_conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int m_hits(input int r);
      int h = 0;
      for (int p = 0; p < WBP; p++)
         if (wb_valid[p] && int'(wb_reg[p*RSEL +: RSEL]) == r) h++;
      return h;
   endfunction

   function automatic logic [XLEN-1:0] m_data(input int sel);
      logic [XLEN-1:0] d;
      if (sel == 0) return '0;
      d = m_file[sel];
      for (int p = 0; p < WBP; p++)
         if (wb_valid[p] && int'(wb_reg[p*RSEL +: RSEL]) == sel) d = wb_val[p*XLEN +: XLEN];
      return d;
   endfunction

   function automatic logic m_busy(input int sel);
      return sel != 0 && (m_cnt[sel] - m_hits(sel)) > 0;
   endfunction

   function automatic logic m_ready();
      if (rst || flush) return 1'b0;
      if (claim_reg == '0) return 1'b1;
      return (m_cnt[claim_reg] - m_hits(int'(claim_reg))) < MAXP;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_cnt[r]  = 0;
         m_file[r] = '0;
      end
      m_pend = 0; m_uf = 0; m_cf = 0;
   endtask

   // Apply one clock edge worth of architectural rules to the model.
   task automatic m_update();
      int  h [NREGS];
      int  n;
      bit  acc;
      if (rst) begin
         m_reset();
         return;
      end
      acc = claim_valid && m_ready();
      for (int r = 0; r < NREGS; r++) h[r] = m_hits(r);
      for (int r = 1; r < NREGS; r++) begin
         if (h[r] >= 2) m_cf = 1;
         if (flush) m_cnt[r] = 0;
         else begin
            n = m_cnt[r] + ((acc && int'(claim_reg) == r) ? 1 : 0) - h[r];
            if (n < 0) begin n = 0; m_uf = 1; end
            m_cnt[r] = n;
         end
      end
      for (int p = 0; p < WBP; p++)
         if (wb_valid[p] && wb_reg[p*RSEL +: RSEL] != '0)
            m_file[wb_reg[p*RSEL +: RSEL]] = wb_val[p*XLEN +: XLEN];
      m_pend = 0;
      for (int r = 0; r < NREGS; r++) if (m_cnt[r] != 0) m_pend = 1;
   endtask

   // Settle inputs and compare combinational outputs against the model.
   task automatic eval();
      #4;
      check($sformatf("data_a[x%0d]", rd_sel_a), rd_data_a, m_data(int'(rd_sel_a)));
      check($sformatf("busy_a[x%0d]", rd_sel_a), 32'(rd_busy_a), 32'(m_busy(int'(rd_sel_a))));
      check($sformatf("data_b[x%0d]", rd_sel_b), rd_data_b, m_data(int'(rd_sel_b)));
      check($sformatf("busy_b[x%0d]", rd_sel_b), 32'(rd_busy_b), 32'(m_busy(int'(rd_sel_b))));
      check($sformatf("claim_ready[x%0d]", claim_reg), 32'(claim_ready), 32'(m_ready()));
   endtask

   // Clock edge, model update, then registered outputs.
   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
      check("pending_any", 32'(pending_any), 32'(m_pend));
      check("err_underflow", 32'(err_underflow), 32'(m_uf));
      check("err_wb_conflict", 32'(err_wb_conflict), 32'(m_cf));
   endtask

   task automatic idle_inputs();
      claim_valid = 1'b0; claim_reg = '0; flush = 1'b0;
      wb_valid = '0; wb_reg = '0; wb_val = '0;
   endtask

   task automatic set_wb(input int p, input int r, input logic [XLEN-1:0] v);
      wb_valid[p] = 1'b1;
      wb_reg[p*RSEL +: RSEL] = RSEL'(r);
      wb_val[p*XLEN +: XLEN] = v;
   endtask

   initial begin
      rst = 1'b1; rd_sel_a = '0; rd_sel_b = '0;
      idle_inputs();
      m_reset();
      @(posedge clk); #1;

      // Held in reset: no claims accepted, everything zero.
      rd_sel_a = 5'd5; rd_sel_b = 5'd31; claim_reg = 5'd3;
      eval();
      check("ready_in_rst", 32'(claim_ready), 32'd0);
      tick();
      rst = 1'b0;

      // Post-reset sweep of every register.
      for (int i = 0; i < 16; i++) begin
         rd_sel_a = RSEL'(i); rd_sel_b = RSEL'(i + 16); claim_reg = RSEL'(i);
         eval();
         check("sweep_data_a", rd_data_a, 32'd0);
         check("sweep_busy_b", 32'(rd_busy_b), 32'd0);
         check("sweep_ready", 32'(claim_ready), 32'd1);
         tick();
      end
      check("sweep_pending", 32'(pending_any), 32'd0);

      // Claim x5, see busy next cycle, then forwarded WB clears it.
      idle_inputs();
      claim_valid = 1'b1; claim_reg = 5'd5;
      eval(); tick();
      claim_valid = 1'b0; rd_sel_a = 5'd5;
      eval();
      check("x5_busy_after_claim", 32'(rd_busy_a), 32'd1);
      tick();
      set_wb(0, 5, 32'hDEADBEEF);
      eval();
      check("x5_bypass_data", rd_data_a, 32'hDEADBEEF);
      check("x5_bypass_busy", 32'(rd_busy_a), 32'd0);
      tick();
      idle_inputs();

      // Saturate x7, then a same-cycle WB frees one slot.
      claim_valid = 1'b1; claim_reg = 5'd7; rd_sel_a = 5'd7;
      for (int i = 0; i < 3; i++) begin eval(); tick(); end
      eval();
      check("x7_sat_ready", 32'(claim_ready), 32'd0);
      set_wb(0, 7, 32'h00000077);
      #1;
      check("x7_wb_ready", 32'(claim_ready), 32'd1);
      tick();
      wb_valid = '0;
      eval();
      check("x7_cnt_stays_3", 32'(claim_ready), 32'd0);
      tick();
      idle_inputs();

      // WB to idle x9: data lands, underflow flagged.
      set_wb(0, 9, 32'h12345678);
      eval(); tick();
      check("x9_underflow", 32'(err_underflow), 32'd1);
      idle_inputs(); rd_sel_b = 5'd9;
      eval();
      check("x9_data", rd_data_b, 32'h12345678);
      tick();

      // Two claims on x3, then both ports hit x3.
      claim_valid = 1'b1; claim_reg = 5'd3;
      eval(); tick(); eval(); tick();
      idle_inputs(); rd_sel_a = 5'd3;
      set_wb(0, 3, 32'h11); set_wb(1, 3, 32'h22);
      eval();
      check("x3_bypass_hi_port", rd_data_a, 32'h22);
      tick();
      check("x3_conflict", 32'(err_wb_conflict), 32'd1);
      idle_inputs();
      eval();
      check("x3_data", rd_data_a, 32'h22);
      check("x3_busy", 32'(rd_busy_a), 32'd0);
      tick();

      // Claims on x1, x2, then flush alongside a claim of x4.
      claim_valid = 1'b1; claim_reg = 5'd1; eval(); tick();
      claim_reg = 5'd2; eval(); tick();
      claim_reg = 5'd4; flush = 1'b1;
      eval();
      check("flush_ready", 32'(claim_ready), 32'd0);
      tick();
      check("flush_pending", 32'(pending_any), 32'd0);
      idle_inputs(); rd_sel_a = 5'd4; rd_sel_b = 5'd1;
      eval();
      check("flush_x4_busy", 32'(rd_busy_a), 32'd0);
      tick();

      // Leave a known value in x6 for the mid-run reset check.
      set_wb(0, 6, 32'hCAFEF00D);
      eval(); tick();
      idle_inputs();

      // Random traffic on a narrow register window to create collisions.
      for (int i = 0; i < 400; i++) begin
         rd_sel_a    = RSEL'($urandom_range(0, 7));
         rd_sel_b    = RSEL'($urandom_range(0, 31));
         claim_valid = ($urandom_range(0, 2) != 0);
         claim_reg   = RSEL'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 15) == 0);
         for (int p = 0; p < WBP; p++) begin
            wb_valid[p] = ($urandom_range(0, 2) == 0);
            wb_reg[p*RSEL +: RSEL] = RSEL'($urandom_range(0, 7));
            wb_val[p*XLEN +: XLEN] = $urandom;
         end
         eval(); tick();
      end

      // Asynchronous reset mid-run zeroes state immediately.
      idle_inputs();
      set_wb(0, 6, 32'hCAFEF00D);
      eval(); tick();
      idle_inputs(); rd_sel_a = 5'd6;
      rst = 1'b1;
      #1;
      m_reset();
      check("async_rst_data", rd_data_a, 32'd0);
      check("async_rst_pending", 32'(pending_any), 32'd0);
      check("async_rst_uf", 32'(err_underflow), 32'd0);
      eval(); tick();
      rst = 1'b0;
      eval(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
